edge_event_reporter: RTL

//  Consumes the 1-bit wireOut produced by the middle stage. Synchronises it

---
 rtl/edge_event_reporter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/edge_event_reporter.sv
// Edge event reporter.
// Synchronises an asynchronous 1-bit input, detects rising and falling edges,
// time-stamps each edge with a free-running counter and queues the events in
// a small FIFO. Events are drained over a valid/ready stream. Edges that
// find the FIFO full are dropped and counted.
module edge_event_reporter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TS_W        = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DROP_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sigIn,
    input  logic              enable,
    input  logic              clrOvf,
    output logic              evtValid,
    input  logic              evtReady,
    output logic [TS_W:0]     evtData,
    output logic              overflow,
    output logic [DROP_W-1:0] dropCnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = TS_W + 1;

    // Synchroniser, edge history and timestamp
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [TS_W-1:0]        ts_q, ts_d;

    // Event FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [DW-1:0]          mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;

    // Registered stream outputs and drop bookkeeping
    logic                   evt_valid_q, evt_valid_d;
    logic [DW-1:0]          evt_data_q, evt_data_d;
    logic                   overflow_q, overflow_d;
    logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;

    // Per-cycle control decisions
    logic                   sync_s;
    logic                   edge_det;
    logic                   fifo_full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [DW-1:0]          push_data;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Front end: shift the synchroniser, remember last synchronised level, advance timestamp
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sigIn};
        prev_d = sync_s;
        ts_d   = ts_q + TS_W'(1);
    end

    // Edge detection and FIFO push/pop/drop decisions
    always_comb begin
        edge_det  = (sync_s != prev_q);
        fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop       = evt_valid_q && evtReady;
        push      = edge_det && enable && (!fifo_full || pop);
        drop      = edge_det && enable && fifo_full && !pop;
        push_data = {sync_s, ts_q};
    end

    // Pointer update and next head-of-queue presentation
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        evt_valid_d = (wr_ptr_d != rd_ptr_d);
        evt_data_d  = evt_data_q;
        if (evt_valid_d) begin
            // A push into the slot that becomes head is only possible when
            // the queue ends up holding just that one entry.
            if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                evt_data_d = push_data;
            end else begin
                evt_data_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Overflow flag and saturating drop counter; a drop beats a same-cycle clear
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clrOvf) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (clrOvf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            prev_q      <= 1'b0;
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            ts_q        <= ts_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // FIFO storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign evtValid = evt_valid_q;
    assign evtData  = evt_data_q;
    assign overflow = overflow_q;
    assign dropCnt  = drop_cnt_q;

endmodule
